// File: rtl/iperm_pkg.sv
// Shared constants for the inverse-permutation key path: key word layout,
// sequencer state encoding and parameter-derived widths.
package iperm_pkg;

  localparam int SLICES     = 8;
  localparam int LOG2SLICES = 3;
  localparam int SELIN      = 2;
  localparam int NUM_TABLES = 4;
  localparam int MAX_SEQ    = 16;
  localparam int CNT_W      = 16;

  localparam int TAB_AW    = $clog2(NUM_TABLES);
  localparam int SEQ_AW    = $clog2(MAX_SEQ);
  localparam int SEQ_LW    = SEQ_AW + 1;
  localparam int ADDR_BITS = SLICES * LOG2SLICES;
  localparam int KW        = SELIN + ADDR_BITS;
  localparam int SEL_LSB   = ADDR_BITS;
  localparam int SEL_MSB   = KW - 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef logic [KW-1:0] key_t;

  // Field extraction shared with the datapath's key slicing.
  function automatic logic [LOG2SLICES-1:0] slice_addr(key_t k, int i);
    return k[LOG2SLICES*i +: LOG2SLICES];
  endfunction

  function automatic logic [SELIN-1:0] key_sel(key_t k);
    return k[SEL_MSB:SEL_LSB];
  endfunction

endpackage

// File: rtl/iperm_key_ram.sv
// Small register file holding complete key words; write is clocked,
// read is combinational so the sequencer can register the key on the same edge.
module iperm_key_ram
  import iperm_pkg::*;
#(
  parameter int DEPTH = NUM_TABLES,
  parameter int WIDTH = KW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/iperm_key_sched.sv
// Key sequencer: streams key words from the key table over a req/ack port,
// walking a programmable schedule of table indices cyclically.
module iperm_key_sched
  import iperm_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [TAB_AW-1:0] cfg_addr,
  input  logic [KW-1:0]     cfg_wdata,
  input  logic              seq_we,
  input  logic [SEQ_AW-1:0] seq_addr,
  input  logic [TAB_AW-1:0] seq_wdata,
  input  logic [SEQ_LW-1:0] seq_len,
  input  logic              start,
  input  logic [CNT_W-1:0]  beats,
  input  logic              abort,
  output logic [KW-1:0]     i_kp_dat,
  output logic              i_kp_req,
  input  logic              i_kp_ack,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  logic [0:0]        state;
  logic [SEQ_AW-1:0] ptr;
  logic [SEQ_AW-1:0] ptr_next;
  logic [SEQ_AW-1:0] rd_slot;
  logic [SEQ_LW-1:0] ptr_inc;
  logic [SEQ_LW-1:0] len_l;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  beats_l;
  logic [TAB_AW-1:0] sched [MAX_SEQ];
  key_t              key_rd;
  logic              xfer;
  logic              last_beat;
  logic              len_ok;
  logic              wr_bad;
  logic              cfg_ok;
  logic              seq_ok;

  assign busy      = (state == ST_RUN);
  assign xfer      = i_kp_req & i_kp_ack;
  assign last_beat = (count == beats_l - CNT_W'(1));
  assign len_ok    = (seq_len != '0) && (seq_len <= SEQ_LW'(MAX_SEQ));

  assign ptr_inc  = {1'b0, ptr} + SEQ_LW'(1);
  assign ptr_next = (ptr_inc == len_l) ? '0 : ptr_inc[SEQ_AW-1:0];
  // In IDLE the only key ever loaded is the one for slot 0.
  assign rd_slot  = (state == ST_RUN) ? ptr_next : '0;

  // Storage may only change while nothing is being streamed from it.
  assign wr_bad = (cfg_we | seq_we) & (busy | start);
  assign cfg_ok = cfg_we & ~wr_bad;
  assign seq_ok = seq_we & ~wr_bad;

  iperm_key_ram #(
    .DEPTH(NUM_TABLES),
    .WIDTH(KW)
  ) u_key_ram (
    .clk  (clk),
    .we   (cfg_ok),
    .waddr(cfg_addr),
    .wdata(cfg_wdata),
    .raddr(sched[rd_slot]),
    .rdata(key_rd)
  );

  always_ff @(posedge clk) begin
    if (seq_ok) sched[seq_addr] <= seq_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      count    <= '0;
      beats_l  <= '0;
      len_l    <= '0;
      i_kp_dat <= '0;
      i_kp_req <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        i_kp_req <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (!len_ok) begin
                cfg_err <= 1'b1;
              end else if (beats == '0) begin
                done <= 1'b1;
              end else begin
                state    <= ST_RUN;
                beats_l  <= beats;
                len_l    <= seq_len;
                ptr      <= '0;
                count    <= '0;
                i_kp_dat <= key_rd;
                i_kp_req <= 1'b1;
                cfg_err  <= 1'b0;
              end
            end
          end
          ST_RUN: begin
            if (xfer) begin
              count <= count + CNT_W'(1);
              if (last_beat) begin
                state    <= ST_IDLE;
                i_kp_req <= 1'b0;
                done     <= 1'b1;
              end else begin
                ptr      <= ptr_next;
                i_kp_dat <= key_rd;
              end
            end
          end
          default: begin
            state    <= ST_IDLE;
            i_kp_req <= 1'b0;
          end
        endcase
      end
      // A rejected write is flagged even when it coincides with an accepted start.
      if (wr_bad) cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iperm_key_sched.sv
// Scoreboard bench for iperm_key_sched: stimulus pushes expected keys,
// an independent negedge monitor pops and compares on every transfer.
module tb_iperm_key_sched;
  import iperm_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [TAB_AW-1:0] cfg_addr = '0;
  logic [KW-1:0]     cfg_wdata = '0;
  logic              seq_we = 1'b0;
  logic [SEQ_AW-1:0] seq_addr = '0;
  logic [TAB_AW-1:0] seq_wdata = '0;
  logic [SEQ_LW-1:0] seq_len = '0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  beats = '0;
  logic              abort = 1'b0;
  logic [KW-1:0]     i_kp_dat;
  logic              i_kp_req;
  logic              i_kp_ack = 1'b0;
  logic              busy;
  logic              done;
  logic              cfg_err;

  key_t              expQ[$];
  key_t              tbTab[NUM_TABLES];
  logic [TAB_AW-1:0] tbSched[MAX_SEQ];
  int                checks = 0;
  int                fails = 0;
  int                doneCount = 0;
  int                xferCount = 0;
  int                busyCycles = 0;
  int                ackMode = 1;
  int                ackPhase = 0;
  logic              prevHold = 1'b0;
  key_t              prevDat = '0;

  iperm_key_sched dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .seq_we   (seq_we),
    .seq_addr (seq_addr),
    .seq_wdata(seq_wdata),
    .seq_len  (seq_len),
    .start    (start),
    .beats    (beats),
    .abort    (abort),
    .i_kp_dat (i_kp_dat),
    .i_kp_req (i_kp_req),
    .i_kp_ack (i_kp_ack),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted key must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prevHold && i_kp_req) checkOutput("hold_stable", 32'(i_kp_dat), 32'(prevDat));
      if (i_kp_req && i_kp_ack && !abort) begin
        xferCount++;
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_key: actual 0x%0h required none", i_kp_dat);
        end else begin
          checkOutput("key", 32'(i_kp_dat), 32'(expQ.pop_front()));
        end
      end
      if (done) doneCount++;
      if (busy) busyCycles++;
      prevHold = i_kp_req && !i_kp_ack && !abort;
      prevDat  = i_kp_dat;
    end else begin
      prevHold = 1'b0;
    end
  end

  // Ack driver: 0 = never, 1 = always, 2 = pattern 1,0,0 repeating.
  always @(posedge clk) begin
    #1;
    case (ackMode)
      0: i_kp_ack = 1'b0;
      1: i_kp_ack = 1'b1;
      default: begin
        i_kp_ack = (ackPhase == 0);
        ackPhase = (ackPhase + 1) % 3;
      end
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic writeTable(input int a, input key_t d, input bit accepted);
    cfg_we = 1'b1; cfg_addr = TAB_AW'(a); cfg_wdata = d;
    tick(1);
    cfg_we = 1'b0;
    if (accepted) tbTab[a] = d;
  endtask

  task automatic writeSched(input int a, input int idx, input bit accepted);
    seq_we = 1'b1; seq_addr = SEQ_AW'(a); seq_wdata = TAB_AW'(idx);
    tick(1);
    seq_we = 1'b0;
    if (accepted) tbSched[a] = TAB_AW'(idx);
  endtask

  task automatic applyStimulus(input int beatsV, input int lenV, input int nPush);
    for (int i = 0; i < nPush; i++) expQ.push_back(tbTab[tbSched[i % lenV]]);
    start = 1'b1; beats = CNT_W'(beatsV); seq_len = SEQ_LW'(lenV);
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (doneCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_reached", 32'(doneCount), 32'(target));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    int b0;
    int x0;
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int b0;
    int x0;
    tick(2);
    checkOutput("reset_req", 32'(i_kp_req), 0);
    checkOutput("reset_dat", 32'(i_kp_dat), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_cfg_err", 32'(cfg_err), 0);
    reset_n = 1'b1;
    tick(1);

    writeTable(0, 26'h0000000, 1'b1);
    writeTable(1, 26'h00FAC68, 1'b1);
    writeTable(2, 26'h01ABCDE, 1'b1);
    writeTable(3, 26'h02FFFFF, 1'b1);
    writeSched(0, 2, 1'b1);
    writeSched(1, 0, 1'b1);
    writeSched(2, 3, 1'b1);

    $display("[TB] test 1: continuous ack, 7 beats over schedule {2,0,3}");
    ackMode = 1;
    d0 = doneCount; b0 = busyCycles;
    applyStimulus(7, 3, 7);
    waitDone(d0 + 1, 50);
    tick(2);
    checkOutput("t1_busy_cycles", 32'(busyCycles - b0), 7);
    checkOutput("t1_done_once", 32'(doneCount - d0), 1);
    checkOutput("t1_queue_empty", 32'(expQ.size()), 0);

    $display("[TB] test 2: ack pattern 1,0,0");
    ackPhase = 0; ackMode = 2;
    d0 = doneCount; x0 = xferCount;
    applyStimulus(7, 3, 7);
    waitDone(d0 + 1, 80);
    tick(2);
    checkOutput("t2_transfers", 32'(xferCount - x0), 7);
    checkOutput("t2_queue_empty", 32'(expQ.size()), 0);

    $display("[TB] test 3: beats=0 and seq_len=0");
    ackMode = 1;
    applyStimulus(0, 3, 0);
    @(negedge clk);
    checkOutput("zero_beats_done", 32'(done), 1);
    checkOutput("zero_beats_req", 32'(i_kp_req), 0);
    @(posedge clk); #1;
    d0 = doneCount;
    applyStimulus(5, 0, 0);
    @(negedge clk);
    checkOutput("zero_len_cfg_err", 32'(cfg_err), 1);
    checkOutput("zero_len_busy", 32'(busy), 0);
    tick(3);
    checkOutput("zero_len_no_done", 32'(doneCount - d0), 0);

    $display("[TB] test 4: table write during RUN is dropped");
    ackMode = 0;
    tick(1);
    d0 = doneCount;
    applyStimulus(7, 3, 7);
    @(negedge clk);
    checkOutput("start_clears_err", 32'(cfg_err), 0);
    checkOutput("t4_busy", 32'(busy), 1);
    @(posedge clk); #1;
    writeTable(1, 26'h3000001, 1'b0);
    @(negedge clk);
    checkOutput("run_write_err", 32'(cfg_err), 1);
    @(posedge clk); #1;
    ackMode = 1;
    waitDone(d0 + 1, 50);
    writeSched(3, 1, 1'b1);
    d0 = doneCount;
    applyStimulus(4, 4, 4);
    waitDone(d0 + 1, 50);
    checkOutput("t4_queue_empty", 32'(expQ.size()), 0);

    $display("[TB] test 5: abort on beat 3 with ack");
    ackMode = 1;
    d0 = doneCount;
    applyStimulus(7, 3, 2);
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_req", 32'(i_kp_req), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    tick(3);
    checkOutput("abort_no_done", 32'(doneCount - d0), 0);
    checkOutput("abort_queue_empty", 32'(expQ.size()), 0);
    applyStimulus(3, 3, 3);
    waitDone(d0 + 1, 50);
    checkOutput("restart_queue_empty", 32'(expQ.size()), 0);

    $display("[TB] test 6: asynchronous reset mid-run");
    ackMode = 0;
    tick(1);
    applyStimulus(7, 3, 0);
    writeTable(2, 26'h1111111, 1'b0);
    tick(2);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_req", 32'(i_kp_req), 0);
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_dat", 32'(i_kp_dat), 0);
    checkOutput("arst_cfg_err", 32'(cfg_err), 0);
    #3;
    reset_n = 1'b1;
    tick(1);
    ackMode = 1;
    tick(1);
    d0 = doneCount;
    applyStimulus(3, 3, 3);
    waitDone(d0 + 1, 50);
    checkOutput("post_reset_queue_empty", 32'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
